// File: rtl/counter_sequencer.sv
// Sequencer for the two LED counters: clear both, pulse A COUNT_A times, then pulse B
// until it wraps (or TIMEOUT_B pulses elapse). All outputs are registered.
module counter_sequencer #(
  parameter int TICK      = 4,
  parameter int COUNT_A   = 8,
  parameter int TIMEOUT_B = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       wrap_b,
  output logic       en_a,
  output logic       en_b,
  output logic       clr,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic [1:0] phase
);
  localparam int PW = $clog2(TICK);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN_A, S_RUN_B, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] psc_q, psc_d;
  logic [4:0]    cnt_q, cnt_d, cnt_inc;
  logic [2:0]    sync_q;
  logic          tmo_q, tmo_d;
  logic          abort_clr, start_edge, tc;
  logic [1:0]    phase_d;
  logic          en_a_q, en_b_q, clr_q, busy_q, done_q;
  logic [1:0]    phase_q;

  always_comb begin
    start_edge = sync_q[1] & ~sync_q[2];
    tc         = (psc_q == PW'(TICK - 1));
    cnt_inc    = cnt_q + 5'd1;
    state_d    = state_q;
    psc_d      = psc_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    abort_clr  = 1'b0;
    case (state_q)
      S_IDLE: if (start_edge) begin
        state_d = S_CLEAR;
        psc_d   = '0;
        cnt_d   = '0;
        tmo_d   = 1'b0;
      end
      S_CLEAR: state_d = S_RUN_A;
      S_RUN_A: if (tc) begin
        psc_d = '0;
        cnt_d = cnt_inc;
        if (cnt_inc == 5'(COUNT_A)) begin
          state_d = S_RUN_B;
          cnt_d   = '0;
        end
      end else psc_d = psc_q + PW'(1);
      // wrap_b wins over a coincident terminal count, so no extra en_b is issued
      S_RUN_B: if (wrap_b) state_d = S_DONE;
      else if (tc) begin
        psc_d = '0;
        cnt_d = cnt_inc;
        if (cnt_inc == 5'(TIMEOUT_B)) begin
          state_d = S_DONE;
          tmo_d   = 1'b1;
        end
      end else psc_d = psc_q + PW'(1);
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && (state_q inside {S_CLEAR, S_RUN_A, S_RUN_B})) begin
      state_d   = S_IDLE;
      psc_d     = '0;
      cnt_d     = '0;
      tmo_d     = tmo_q;
      abort_clr = 1'b1;
    end
    case (state_d)
      S_IDLE:  phase_d = 2'd0;
      S_RUN_A: phase_d = 2'd1;
      S_RUN_B: phase_d = 2'd2;
      default: phase_d = 2'd3;
    endcase
  end

  // Outputs are computed from next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      state_q <= S_IDLE;
      psc_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
      en_a_q  <= 1'b0;
      en_b_q  <= 1'b0;
      clr_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      phase_q <= 2'd0;
    end else begin
      sync_q  <= {sync_q[1:0], start};
      state_q <= state_d;
      psc_q   <= psc_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      en_a_q  <= (state_d == S_RUN_A) && (psc_d == PW'(TICK - 1));
      en_b_q  <= (state_d == S_RUN_B) && (psc_d == PW'(TICK - 1));
      clr_q   <= (state_d == S_CLEAR) || abort_clr;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
      phase_q <= phase_d;
    end
  end

  assign en_a    = en_a_q;
  assign en_b    = en_b_q;
  assign clr     = clr_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign timeout = tmo_q;
  assign phase   = phase_q;
endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: default and corner-parameter instances checked every cycle
// against a timeline model built from the run plan (pulse times, wrap, abort, reset).
module tb_counter_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] start_v, abort_v, wrap_v;
  logic [7:0] obs [2];
  int         n_chk = 0, n_fail = 0;

  logic       en_a0, en_b0, clr0, busy0, done0, tmo0;
  logic       en_a1, en_b1, clr1, busy1, done1, tmo1;
  logic [1:0] ph0, ph1;

  always #5 clk = ~clk;

  counter_sequencer #(.TICK(4), .COUNT_A(8), .TIMEOUT_B(16)) u_dut (
    .clk(clk), .reset(rst_n), .start(start_v[0]), .abort(abort_v[0]), .wrap_b(wrap_v[0]),
    .en_a(en_a0), .en_b(en_b0), .clr(clr0), .busy(busy0), .done(done0), .timeout(tmo0),
    .phase(ph0));

  counter_sequencer #(.TICK(2), .COUNT_A(1), .TIMEOUT_B(1)) u_dut_c (
    .clk(clk), .reset(rst_n), .start(start_v[1]), .abort(abort_v[1]), .wrap_b(wrap_v[1]),
    .en_a(en_a1), .en_b(en_b1), .clr(clr1), .busy(busy1), .done(done1), .timeout(tmo1),
    .phase(ph1));

  // {en_a, en_b, clr, busy, done, timeout, phase[1:0]}
  assign obs[0] = {en_a0, en_b0, clr0, busy0, done0, tmo0, ph0};
  assign obs[1] = {en_a1, en_b1, clr1, busy1, done1, tmo1, ph1};

  function automatic int tk(int d);  return d ? 2 : 4;  endfunction
  function automatic int ca(int d);  return d ? 1 : 8;  endfunction
  function automatic int tbm(int d); return d ? 1 : 16; endfunction

  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected outputs t cycles after the clr cycle of a run.
  function automatic logic [7:0] model(int d, int t, int tw, int ta);
    int   tA, tend;
    logic tmo, ea, eb, cl, bs, dn, to;
    logic [1:0] ph;
    tA = ca(d) * tk(d);
    if (tw >= 0) begin tend = tw; tmo = 1'b0; end
    else begin tend = tA + tbm(d) * tk(d); tmo = 1'b1; end
    {ea, eb, cl, bs, dn, to, ph} = '0;
    if (ta >= 0 && ta <= tend && t > ta) cl = (t == ta + 1);
    else if (t == 0) begin cl = 1'b1; bs = 1'b1; ph = 2'd3; end
    else if (t <= tA) begin bs = 1'b1; ph = 2'd1; ea = (t % tk(d) == 0); end
    else if (t <= tend) begin bs = 1'b1; ph = 2'd2; eb = ((t - tA) % tk(d) == 0); end
    else if (t == tend + 1) begin bs = 1'b1; ph = 2'd3; dn = 1'b1; to = tmo; end
    else to = tmo;
    return {ea, eb, cl, bs, dn, to, ph};
  endfunction

  // tw: cycle wrap_b is high (-1 none); ta: abort cycle (-1 none); rs: reset cycle (-1 none)
  task automatic run(int d, int tw, int ta, bit tgl, int rs);
    int tA, tend, stop, last, lat;
    tA   = ca(d) * tk(d);
    tend = (tw >= 0) ? tw : tA + tbm(d) * tk(d);
    stop = (ta >= 0 && ta <= tend) ? ta : tend;
    last = (ta >= 0 && ta <= tend) ? ta + 4 : tend + 5;
    start_v[d] = 1'b0;
    repeat (3) @(negedge clk);
    start_v[d] = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!obs[d][5] && lat < 8);
    chk($sformatf("d%0d_clr_lat", d), 8'(lat), (lat == 4) ? 8'd4 : 8'd3);
    for (int t = 0; t <= last; t++) begin
      if (t > 0) @(negedge clk);
      chk($sformatf("d%0d_t%0d", d, t), obs[d], model(d, t, tw, ta));
      if (t == rs) begin
        rst_n = 1'b0;
        start_v = '0; abort_v = '0; wrap_v = '0;
        #1;
        chk("rst_async0", obs[0], 8'h00);
        chk("rst_async1", obs[1], 8'h00);
        @(negedge clk);
        chk("rst_hold", obs[d], 8'h00);
        rst_n = 1'b1;
        return;
      end
      wrap_v[d]  = (t == tw);
      abort_v[d] = (t == ta);
      if (tgl && t > 0 && t + 4 < stop) start_v[d] = 1'($urandom_range(0, 1));
    end
    wrap_v[d]  = 1'b0;
    abort_v[d] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, tA, tT, tw, ta, tend;
    rst_n = 1'b0; start_v = '0; abort_v = '0; wrap_v = '0;
    repeat (2) @(negedge clk);
    chk("reset0", obs[0], 8'h00);
    chk("reset1", obs[1], 8'h00);
    rst_n = 1'b1;

    run(0, -1, -1, 1'b0, 3 * 4 + 1);          // reset after the 3rd en_a
    run(0, 32 + 5 * 4, -1, 1'b0, -1);         // nominal: wrap with 5th en_b
    run(0, -1, -1, 1'b0, -1);                 // timeout
    run(0, 32 + 5 * 4, -1, 1'b0, -1);         // timeout cleared by the next run
    run(0, 32 + 9, 32 + 9, 1'b0, -1);         // abort and wrap together in RUN_B
    run(0, -1, -1, 1'b1, -1);                 // start toggling during RUN_A
    run(1, -1, -1, 1'b0, -1);                 // corner parameters, timeout
    run(1, 3, -1, 1'b0, -1);                  // corner parameters, wrap

    for (int i = 0; i < 24; i++) begin
      d  = int'($urandom_range(0, 1));
      tA = ca(d) * tk(d);
      tT = tA + tbm(d) * tk(d);
      tw = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(tA + 1, tT - 1));
      tend = (tw >= 0) ? tw : tT;
      ta = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, tend + 2)) : -1;
      run(d, tw, ta, 1'($urandom_range(0, 1)), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
